// File: rtl/mem_pkg.sv
// Shared types for the byte-serial memory controller.
// State encoding, IO window select and RAM byte type.
package mem_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_READ,
      S_WRITE,
      S_DONE
   } state_e;

   localparam logic [1:0] IO_SEL = 2'b11;

   typedef logic [7:0] ram_byte_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant picker, purely combinational.
// First eligible port at or after the pointer wins.
module rr_arbiter
   import mem_pkg::*;
#(
   parameter int NUM_PORTS = 2,
   parameter int PTR_W     = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
   input  logic [NUM_PORTS-1:0] elig_i,
   input  logic [PTR_W-1:0]     ptr_i,
   output logic [NUM_PORTS-1:0] gnt_o,
   output logic [PTR_W-1:0]     idx_o,
   output logic                 any_o
);

   // scan pointer..top first, then wrap to 0..pointer-1
   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      any_o = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!any_o && elig_i[i] && (i >= int'(ptr_i))) begin
            gnt_o[i] = 1'b1;
            idx_o    = PTR_W'(i);
            any_o    = 1'b1;
         end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (!any_o && elig_i[i] && (i < int'(ptr_i))) begin
            gnt_o[i] = 1'b1;
            idx_o    = PTR_W'(i);
            any_o    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mem_ctrl_rr.sv
// Round-robin byte-serial controller for an 8-bit sync RAM/IO bus.
// Serialises 1..DATA_BYTES reads/writes; IO writes wait on UART full.
module mem_ctrl_rr
   import mem_pkg::*;
#(
   parameter int NUM_PORTS  = 2,
   parameter int ADDR_W     = 32,
   parameter int RAM_ADDR_W = 18,
   parameter int DATA_BYTES = 4,
   parameter int LEN_W      = $clog2(DATA_BYTES) + 1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             rdy,
   input  logic [7:0]                       ram_din,
   input  logic                             io_buffer_full,
   output logic                             ram_wr,
   output logic [RAM_ADDR_W-1:0]            ram_a,
   output logic [7:0]                       ram_dout,
   input  logic [NUM_PORTS-1:0]             req,
   input  logic [NUM_PORTS-1:0]             we,
   input  logic [NUM_PORTS*LEN_W-1:0]       len,
   input  logic [NUM_PORTS*ADDR_W-1:0]      addr,
   input  logic [NUM_PORTS*DATA_BYTES*8-1:0] wdata,
   output logic [NUM_PORTS-1:0]             done,
   output logic [DATA_BYTES*8-1:0]          rdata
);

   localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int CNT_W = LEN_W + 1;
   localparam int DW    = DATA_BYTES * 8;

   state_e                state_q, state_d;
   logic [PTR_W-1:0]      ptr_q, ptr_d;
   logic [PTR_W-1:0]      id_q, id_d;
   logic [RAM_ADDR_W-1:0] base_q, base_d;
   logic [CNT_W-1:0]      n_q, n_d;
   logic [CNT_W-1:0]      step_q, step_d;
   logic [DW-1:0]         wdata_q, wdata_d;
   logic                  ram_wr_q, ram_wr_d;
   logic [RAM_ADDR_W-1:0] ram_a_q, ram_a_d;
   ram_byte_t             ram_dout_q, ram_dout_d;
   logic [NUM_PORTS-1:0]  done_q, done_d;
   logic [DW-1:0]         rdata_q, rdata_d;

   logic [NUM_PORTS-1:0]  elig;
   logic [NUM_PORTS-1:0]  gnt;
   logic [PTR_W-1:0]      gnt_idx;
   logic                  any_elig;
   logic                  sel_we;
   logic [RAM_ADDR_W-1:0] sel_addr;
   logic [LEN_W-1:0]      sel_len;
   logic [DW-1:0]         sel_wdata;
   logic [CNT_W-1:0]      n_sel;
   logic                  cur_req;
   logic                  abort;
   logic [CNT_W-1:0]      j;
   logic                  unused_addr;

   assign unused_addr = ^addr;

   // a blocked IO write steps aside so other ports can still win
   always_comb begin
      elig = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         elig[i] = req[i] &&
                   !(we[i] && (addr[i*ADDR_W+16 +: 2] == IO_SEL) &&
                     io_buffer_full);
      end
   end

   rr_arbiter #(
      .NUM_PORTS(NUM_PORTS),
      .PTR_W    (PTR_W)
   ) u_arb (
      .elig_i(elig),
      .ptr_i (ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (any_elig)
   );

   // mux out the winner's request and the latched owner's live req
   always_comb begin
      sel_we    = 1'b0;
      sel_addr  = '0;
      sel_len   = '0;
      sel_wdata = '0;
      cur_req   = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (gnt[i]) begin
            sel_we    = we[i];
            sel_addr  = addr[i*ADDR_W +: RAM_ADDR_W];
            sel_len   = len[i*LEN_W +: LEN_W];
            sel_wdata = wdata[i*DW +: DW];
         end
         if (PTR_W'(i) == id_q) cur_req = req[i];
      end
      n_sel = CNT_W'(sel_len);
      if ((sel_len == '0) || (n_sel > CNT_W'(DATA_BYTES)))
         n_sel = CNT_W'(DATA_BYTES);
   end

   assign abort = !cur_req;
   assign j     = step_q + CNT_W'(1);

   // state register; rdy low freezes everything
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   state_q <= S_IDLE;
      else if (rdy) state_q <= state_d;
   end

   // reads finish one edge later than writes (RAM read latency)
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:
            if (any_elig) state_d = sel_we ? S_WRITE : S_READ;
         S_READ:
            if (abort)                      state_d = S_IDLE;
            else if (j == n_q + CNT_W'(1)) state_d = S_DONE;
         S_WRITE:
            if (abort)         state_d = S_IDLE;
            else if (j == n_q) state_d = S_DONE;
         S_DONE:
            state_d = S_IDLE;
         default:
            state_d = S_IDLE;
      endcase
   end

   // bus drive, byte capture, latching and done pulse
   always_comb begin
      ptr_d      = ptr_q;
      id_d       = id_q;
      base_d     = base_q;
      n_d        = n_q;
      step_d     = step_q;
      wdata_d    = wdata_q;
      ram_wr_d   = ram_wr_q;
      ram_a_d    = ram_a_q;
      ram_dout_d = ram_dout_q;
      rdata_d    = rdata_q;
      done_d     = '0;
      unique case (state_q)
         S_IDLE: begin
            if (any_elig) begin
               id_d     = gnt_idx;
               ptr_d    = (gnt_idx == PTR_W'(NUM_PORTS - 1)) ?
                          '0 : gnt_idx + PTR_W'(1);
               base_d   = sel_addr;
               n_d      = n_sel;
               wdata_d  = sel_wdata;
               step_d   = '0;
               ram_a_d  = sel_addr;
               ram_wr_d = sel_we;
               if (sel_we) ram_dout_d = sel_wdata[7:0];
               else        rdata_d    = '0;
            end
         end
         S_READ: begin
            step_d = j;
            if (abort) begin
               ram_wr_d = 1'b0;
               ram_a_d  = '0;
            end else begin
               if (j < n_q) ram_a_d = base_q + RAM_ADDR_W'(j);
               else         ram_a_d = '0;
               for (int k = 0; k < DATA_BYTES; k++) begin
                  if (j == CNT_W'(k + 2)) rdata_d[8*k +: 8] = ram_din;
               end
               if (j == n_q + CNT_W'(1)) begin
                  for (int i = 0; i < NUM_PORTS; i++) begin
                     if (PTR_W'(i) == id_q) done_d[i] = 1'b1;
                  end
               end
            end
         end
         S_WRITE: begin
            step_d = j;
            if (abort) begin
               ram_wr_d = 1'b0;
               ram_a_d  = '0;
            end else if (j < n_q) begin
               ram_a_d = base_q + RAM_ADDR_W'(j);
               for (int k = 0; k < DATA_BYTES; k++) begin
                  if (j == CNT_W'(k)) ram_dout_d = wdata_q[8*k +: 8];
               end
            end else begin
               ram_wr_d = 1'b0;
               ram_a_d  = '0;
               for (int i = 0; i < NUM_PORTS; i++) begin
                  if (PTR_W'(i) == id_q) done_d[i] = 1'b1;
               end
            end
         end
         S_DONE: begin
         end
         default: begin
         end
      endcase
   end

   // datapath and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         id_q       <= '0;
         base_q     <= '0;
         n_q        <= '0;
         step_q     <= '0;
         wdata_q    <= '0;
         ram_wr_q   <= 1'b0;
         ram_a_q    <= '0;
         ram_dout_q <= '0;
         done_q     <= '0;
         rdata_q    <= '0;
      end else if (rdy) begin
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         base_q     <= base_d;
         n_q        <= n_d;
         step_q     <= step_d;
         wdata_q    <= wdata_d;
         ram_wr_q   <= ram_wr_d;
         ram_a_q    <= ram_a_d;
         ram_dout_q <= ram_dout_d;
         done_q     <= done_d;
         rdata_q    <= rdata_d;
      end
   end

   assign ram_wr   = ram_wr_q;
   assign ram_a    = ram_a_q;
   assign ram_dout = ram_dout_q;
   assign done     = done_q;
   assign rdata    = rdata_q;

endmodule

// File: tb/tb_mem_ctrl_rr.sv
// Bench for mem_ctrl_rr: sync RAM model, transaction-level
// reference model with per-cycle compare, directed scenarios.
module tb_mem_ctrl_rr;

   localparam int NP  = 2;
   localparam int AW  = 32;
   localparam int RAW = 18;
   localparam int DB  = 4;
   localparam int LW  = 3;
   localparam int DW  = 32;
   localparam int SZ  = 1 << RAW;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             rdy = 1'b0;
   logic             io_full = 1'b0;
   logic [7:0]       ram_din = 8'h00;
   logic             ram_wr;
   logic [RAW-1:0]   ram_a;
   logic [7:0]       ram_dout;
   logic [NP-1:0]    req = '0;
   logic [NP-1:0]    we = '0;
   logic [NP*LW-1:0] len = '0;
   logic [NP*AW-1:0] addr = '0;
   logic [NP*DW-1:0] wdata = '0;
   logic [NP-1:0]    done;
   logic [DW-1:0]    rdata;

   int n_run = 0;
   int n_fail = 0;

   logic [7:0] ram [SZ];
   logic [7:0] gm  [SZ];

   mem_ctrl_rr #(
      .NUM_PORTS(NP), .ADDR_W(AW), .RAM_ADDR_W(RAW),
      .DATA_BYTES(DB), .LEN_W(LW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rdy(rdy), .ram_din(ram_din),
      .io_buffer_full(io_full), .ram_wr(ram_wr), .ram_a(ram_a),
      .ram_dout(ram_dout), .req(req), .we(we), .len(len),
      .addr(addr), .wdata(wdata), .done(done), .rdata(rdata)
   );

   initial forever #5 clk = ~clk;

   // synchronous RAM, frozen while rdy is low
   always @(posedge clk) begin
      if (rdy) begin
         if (ram_wr) ram[ram_a] <= ram_dout;
         ram_din <= ram[ram_a];
      end
   end

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int             m_ph = 0;
   int             m_ptr = 0;
   int             m_port = 0;
   int             m_j = 0;
   int             m_n = 0;
   logic           m_we = 1'b0;
   logic [RAW-1:0] m_a = '0;
   logic [DW-1:0]  m_wd = '0;
   logic [NP-1:0]  m_elig;
   int             m_g;
   logic           exp_wr = 1'b0;
   logic [RAW-1:0] exp_a = '0;
   logic [7:0]     exp_dout = '0;
   logic [NP-1:0]  exp_done = '0;
   logic [DW-1:0]  exp_rdata = '0;

   function automatic int pick(logic [NP-1:0] el, int ptr);
      for (int k = 0; k < NP; k++)
         if (el[(ptr + k) % NP]) return (ptr + k) % NP;
      return -1;
   endfunction

   function automatic int norm(int l);
      return (l == 0 || l > DB) ? DB : l;
   endfunction

   function automatic logic [DW-1:0] gm_word(logic [RAW-1:0] a, int n);
      logic [DW-1:0] w;
      w = '0;
      for (int k = 0; k < n; k++) w[8*k +: 8] = gm[(int'(a) + k) % SZ];
      return w;
   endfunction

   always_comb begin
      m_elig = '0;
      for (int i = 0; i < NP; i++)
         m_elig[i] = req[i] && !(we[i] && addr[i*AW+16 +: 2] == 2'b11 && io_full);
      m_g = pick(m_elig, m_ptr);
   end

   // ph 0 = idle, 1 = transferring, 2 = done cycle; m_j = edges since grant - 1
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_ph <= 0; m_ptr <= 0;
         exp_wr <= 1'b0; exp_a <= '0; exp_dout <= '0;
         exp_done <= '0; exp_rdata <= '0;
      end else if (rdy) begin
         case (m_ph)
            0: if (m_g >= 0) begin
               m_port <= m_g;
               m_we   <= we[m_g];
               m_a    <= addr[m_g*AW +: RAW];
               m_n    <= norm(int'(len[m_g*LW +: LW]));
               m_wd   <= wdata[m_g*DW +: DW];
               m_j    <= 0;
               m_ptr  <= (m_g + 1) % NP;
               exp_a  <= addr[m_g*AW +: RAW];
               exp_wr <= we[m_g];
               if (we[m_g]) exp_dout <= wdata[m_g*DW +: 8];
               m_ph   <= 1;
            end
            1: begin
               m_j <= m_j + 1;
               if (!req[m_port]) begin
                  exp_wr <= 1'b0; exp_a <= '0; m_ph <= 0;
                  if (m_we) gm[(int'(m_a) + m_j) % SZ] <= m_wd[8*m_j +: 8];
               end else if (m_we) begin
                  gm[(int'(m_a) + m_j) % SZ] <= m_wd[8*m_j +: 8];
                  if (m_j + 1 < m_n) begin
                     exp_a    <= RAW'(int'(m_a) + m_j + 1);
                     exp_dout <= m_wd[8*(m_j+1) +: 8];
                  end else begin
                     exp_wr <= 1'b0; exp_a <= '0;
                     exp_done[m_port] <= 1'b1; m_ph <= 2;
                  end
               end else begin
                  if (m_j + 1 < m_n) exp_a <= RAW'(int'(m_a) + m_j + 1);
                  else               exp_a <= '0;
                  if (m_j + 1 == m_n + 1) begin
                     exp_done[m_port] <= 1'b1;
                     exp_rdata <= gm_word(m_a, m_n);
                     m_ph <= 2;
                  end
               end
            end
            default: begin
               exp_done <= '0; m_ph <= 0;
            end
         endcase
      end
   end

   // per-cycle compare away from the active edge
   always @(negedge clk) begin
      chk("ram_wr", 64'(ram_wr), 64'(exp_wr));
      chk("ram_a", 64'(ram_a), 64'(exp_a));
      chk("done", 64'(done), 64'(exp_done));
      if (exp_wr) chk("ram_dout", 64'(ram_dout), 64'(exp_dout));
      if (exp_done != '0) chk("rdata", 64'(rdata), 64'(exp_rdata));
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_port(int p, logic w, int l, logic [31:0] a, logic [31:0] d);
      we[p] = w;
      len[p*LW +: LW] = LW'(l);
      addr[p*AW +: AW] = a;
      wdata[p*DW +: DW] = d;
   endtask

   task automatic wait_done(output int port);
      port = -1;
      for (int c = 0; c < 40 && port < 0; c++) begin
         step();
         if (done != '0) port = done[1] ? 1 : 0;
      end
      if (port < 0) begin
         n_run++;
         n_fail++;
         $display("FAIL wait_done: no done pulse within 40 cycles");
      end
   endtask

   int p;
   int lt [3] = '{0, 3, 5};
   logic [31:0] rt [3] = '{32'h44332211, 32'h00332211, 32'h44332211};
   int wa [4] = '{'h200, 'h201, 'h202, 'h203};
   logic [7:0] wb [4] = '{8'hD4, 8'hC3, 8'hB2, 8'hA1};

   initial begin
      for (int i = 0; i < SZ; i++) begin
         ram[i] = 8'((i * 7 + 3) & 255);
         gm[i]  = 8'((i * 7 + 3) & 255);
      end
      ram['h100] = 8'h11; ram['h101] = 8'h22;
      ram['h102] = 8'h33; ram['h103] = 8'h44;
      gm['h100] = 8'h11; gm['h101] = 8'h22;
      gm['h102] = 8'h33; gm['h103] = 8'h44;
      rst_n = 1'b0;
      rdy = 1'b1;
      step(); step();
      chk("rst_wr", 64'(ram_wr), 64'(0));
      chk("rst_a", 64'(ram_a), 64'(0));
      chk("rst_dout", 64'(ram_dout), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_rdata", 64'(rdata), 64'(0));
      rst_n = 1'b1;
      step();

      // 4-byte read
      set_port(0, 1'b0, 4, 32'h100, 32'h0);
      req[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         step();
         chk("t1_addr", 64'(ram_a), 64'('h100 + k));
      end
      step();
      chk("t1_addr_idle", 64'(ram_a), 64'(0));
      step();
      chk("t1_done", 64'(done), 64'(2'b01));
      chk("t1_rdata", 64'(rdata), 64'(32'h44332211));
      req[0] = 1'b0;
      step();
      chk("t1_done_clr", 64'(done), 64'(0));

      // 2-byte write
      set_port(1, 1'b1, 2, 32'h20, 32'h0000BEEF);
      req[1] = 1'b1;
      step();
      chk("t2_wr", 64'(ram_wr), 64'(1));
      chk("t2_a0", 64'(ram_a), 64'('h20));
      chk("t2_d0", 64'(ram_dout), 64'(8'hEF));
      step();
      chk("t2_a1", 64'(ram_a), 64'('h21));
      chk("t2_d1", 64'(ram_dout), 64'(8'hBE));
      step();
      chk("t2_done", 64'(done), 64'(2'b10));
      chk("t2_wr_off", 64'(ram_wr), 64'(0));
      req[1] = 1'b0;
      step();
      chk("t2_mem0", 64'(ram['h20]), 64'(8'hEF));
      chk("t2_mem1", 64'(ram['h21]), 64'(8'hBE));

      // fairness: both requesting, alternate grants
      set_port(0, 1'b0, 1, 32'h100, 32'h0);
      set_port(1, 1'b0, 1, 32'h101, 32'h0);
      req = 2'b11;
      for (int g = 0; g < 8; g++) begin
         wait_done(p);
         chk("t3_grant", 64'(p), 64'(g % 2));
         if (p >= 0) req[p] = 1'b0;
         step();
         if (p >= 0) req[p] = 1'b1;
      end
      req = '0;
      step();

      // blocked IO write lets port0 through even with pointer on port1
      set_port(1, 1'b1, 1, 32'h30000, 32'h5A);
      set_port(0, 1'b0, 1, 32'h102, 32'h0);
      io_full = 1'b1;
      req = 2'b11;
      wait_done(p);
      chk("t4_first", 64'(p), 64'(0));
      req[0] = 1'b0;
      step();
      req[0] = 1'b1;
      wait_done(p);
      chk("t4_skip", 64'(p), 64'(0));
      req[0] = 1'b0;
      step(); step(); step();
      chk("t4_hold", 64'(ram_wr), 64'(0));
      io_full = 1'b0;
      step();
      chk("t4_io_a", 64'(ram_a), 64'(18'h30000));
      chk("t4_io_wr", 64'(ram_wr), 64'(1));
      io_full = 1'b1;
      wait_done(p);
      chk("t4_io_done", 64'(p), 64'(1));
      req[1] = 1'b0;
      io_full = 1'b0;
      step();
      chk("t4_io_mem", 64'(ram[18'h30000]), 64'(8'h5A));

      // abort after E1, then port1 served
      set_port(0, 1'b0, 4, 32'h100, 32'h0);
      set_port(1, 1'b0, 1, 32'h40, 32'h0);
      req = 2'b11;
      step();
      chk("t5_a0", 64'(ram_a), 64'('h100));
      step();
      chk("t5_a1", 64'(ram_a), 64'('h101));
      req[0] = 1'b0;
      step();
      chk("t5_abort_a", 64'(ram_a), 64'(0));
      chk("t5_abort_done", 64'(done), 64'(0));
      step();
      chk("t5_p1_a", 64'(ram_a), 64'('h40));
      wait_done(p);
      chk("t5_p1_done", 64'(p), 64'(1));
      req[1] = 1'b0;
      step();

      // len boundaries: 0 and >DATA_BYTES mean full width
      for (int t = 0; t < 3; t++) begin
         set_port(0, 1'b0, lt[t], 32'h100, 32'h0);
         req[0] = 1'b1;
         wait_done(p);
         chk("len_rdata", 64'(rdata), 64'(rt[t]));
         req[0] = 1'b0;
         step();
      end

      // rdy low mid-write freezes the bus
      set_port(0, 1'b1, 4, 32'h200, 32'hA1B2C3D4);
      req[0] = 1'b1;
      step();
      chk("t6_a0", 64'(ram_a), 64'('h200));
      chk("t6_d0", 64'(ram_dout), 64'(8'hD4));
      step();
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         chk("t6_frz_a", 64'(ram_a), 64'('h201));
         chk("t6_frz_d", 64'(ram_dout), 64'(8'hC3));
         chk("t6_frz_wr", 64'(ram_wr), 64'(1));
      end
      rdy = 1'b1;
      step();
      chk("t6_a2", 64'(ram_a), 64'('h202));
      chk("t6_d2", 64'(ram_dout), 64'(8'hB2));
      wait_done(p);
      chk("t6_wdone", 64'(p), 64'(0));
      req[0] = 1'b0;
      step();
      for (int k = 0; k < 4; k++) begin
         chk("t6_mem", 64'(ram[wa[k]]), 64'(wb[k]));
         chk("gm_vs_ram", 64'(ram[wa[k]]), 64'(gm[wa[k]]));
      end

      // reset mid-read with pointer on port1
      set_port(0, 1'b0, 4, 32'h100, 32'h0);
      req[0] = 1'b1;
      step(); step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t7_rst_a", 64'(ram_a), 64'(0));
      chk("t7_rst_wr", 64'(ram_wr), 64'(0));
      chk("t7_rst_done", 64'(done), 64'(0));
      chk("t7_rst_rdata", 64'(rdata), 64'(0));
      chk("t7_rst_dout", 64'(ram_dout), 64'(0));
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      set_port(0, 1'b0, 1, 32'h100, 32'h0);
      set_port(1, 1'b0, 1, 32'h103, 32'h0);
      req = 2'b11;
      step();
      chk("t7_ptr0", 64'(ram_a), 64'('h100));
      wait_done(p);
      chk("t7_grant", 64'(p), 64'(0));
      req = '0;
      step(); step();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_ctrl_rr.md
# mem_ctrl_rr

Parametrised byte-serial memory controller sitting between NUM_PORTS requesters (instruction fetch, load/store buffer, future D-cache refill) and the single-ported 8-bit synchronous RAM/IO bus. It arbitrates round-robin, serialises 1..DATA_BYTES-byte reads and writes, holds IO writes while the UART buffer is full, and supports requester abort mid-transfer.

## Interface
- NUM_PORTS, 2, number of requesters (≥1)
- ADDR_W, 32, requester address width
- RAM_ADDR_W, 18, RAM-side address width (low bits of requester address)
- DATA_BYTES, 4, max access size in bytes (power of 2)
- LEN_W, $clog2(DATA_BYTES)+1, width of per-port byte count
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rdy  in  1  global enable; low freezes all state and outputs
- ram_din  in  8  RAM read byte, valid the cycle after its address
- io_buffer_full  in  1  UART TX buffer full
- ram_wr  out  1  1 = write, 0 = read
- ram_a  out  RAM_ADDR_W  RAM byte address
- ram_dout  out  8  RAM write byte
- req  in  NUM_PORTS  per-port request, held until done or abort
- we  in  NUM_PORTS  per-port 1 = write
- len  in  NUM_PORTS*LEN_W  per-port byte count
- addr  in  NUM_PORTS*ADDR_W  per-port start address
- wdata  in  NUM_PORTS*DATA_BYTES*8  per-port write data, byte 0 = LSB
- done  out  NUM_PORTS  one-cycle completion pulse, one-hot
- rdata  out  DATA_BYTES*8  shared read data, valid while done[i] high

## Operation
- States: IDLE, READ, WRITE, DONE.
- Eligibility: port i eligible if req[i] and not (we[i] and addr[i][17:16]==2'b11 and io_buffer_full). Ineligible IO writes wait; other ports may win.
- IDLE: if any eligible, grant first eligible at or after rr pointer (wrapping); latch port id, addr, len, we, wdata; pointer <= grant+1 mod NUM_PORTS. Drive ram_a <= addr[RAM_ADDR_W-1:0]; write: ram_wr <= 1, ram_dout <= byte0; read: ram_wr <= 0. Go WRITE/READ.
- len outside 1..DATA_BYTES treated as DATA_BYTES.
- READ: addresses A..A+len-1 issued on consecutive cycles; byte k captured from ram_din one cycle after address A+k issued; after last address ram_a <= 0. Unused upper rdata bytes zero. After last capture: done[id] <= 1, go DONE.
- WRITE: byte k on ram_dout with ram_a = A+k, one per cycle. After last byte: ram_wr <= 0, ram_a <= 0, done[id] <= 1, go DONE.
- DONE: done low next cycle, no grant this cycle; go IDLE. Requester must drop req in the cycle done is high.
- Abort: granted port's req low in READ/WRITE → ram_wr <= 0, ram_a <= 0, no done, go IDLE. Bytes already written stay written.
- Mid-transfer change of we/len/addr/wdata of the granted port is ignored (latched).
- rst_n low at any time: immediate return to IDLE, pointer 0, all outputs 0.

## Timing
- Reset values: ram_wr 0, ram_a 0, ram_dout 0, done 0, rdata 0.
- Grant edge = E0. Read of N bytes: done high in cycle after edge E(N+1). Write of N bytes: done high after edge E(N).
- Back-to-back: next grant earliest at edge after DONE cycle → read-to-read issue gap N+3 cycles for N bytes.
- rdy low: no state, counter, pointer or output update; ram_din sampled only on rdy-high edges (RAM also frozen).
- io_buffer_full sampled only at grant; once granted an IO write completes regardless.
- All outputs registered.

## Structure
- Shared package mem_pkg: state enum, IO_SEL constant (2'b11 on addr[17:16]), ram byte type.
- Sub-module rr_arbiter (NUM_PORTS): eligible vector + pointer in, one-hot grant + index out, purely combinational; pointer register stays in mem_ctrl_rr.

## Test plan
- Port0 read len=4 at 0x100, RAM bytes 11,22,33,44 → ram_a 0x100..0x103 on E0..E3, done[0] after E5, rdata=0x44332211.
- Port1 write len=2 addr 0x20, wdata=0xBEEF → ram_wr=1, (0x20,EF),(0x21,BE) on E0,E1; done[1] after E2; ram_wr 0.
- Both ports requesting continuously, pointer=0 → grants 0,1,0,1; no starvation over 8 grants.
- Port1 write to 0x30000 with io_buffer_full=1, port0 read pending → port0 served; port1 granted first IDLE after io_buffer_full falls.
- Port0 drops req after E1 of a 4-byte read → no done, IDLE next cycle, port1 granted following cycle.
- rdy low 3 cycles mid-write, then rst_n pulsed mid-read → outputs frozen during rdy low; all outputs 0 and pointer 0 immediately on rst_n low.
